// File: rtl/mc_ctrl_unit.sv
// -----------------------------------------------------------------------------
// mc_ctrl_unit -- multi-cycle MIPS-style control unit.
//
// Sequences instruction fetch, decode, memory access, ALU execute, write-back,
// branch and jump through a Moore-style FSM. Memory states (IF/MRD/MWR) wait
// for MIO_ready. A watchdog counter moves the FSM to a sticky ERR state if
// MIO_ready stays low for TIMEOUT consecutive cycles. Only rst leaves ERR.
//
// Optional feature (macro MC_OVF_TRAP_EN):
//   When defined, signed overflow on R-type add/sub or addi diverts the FSM
//   from write-back to TRAP. TRAP loads the trap vector (PCSource=11) and
//   pulses trap for one cycle. When undefined, overflow is ignored and
//   trap is tied 0.
//
// Parameters:
//   TIMEOUT        maximum consecutive MIO_ready-low cycles in a memory state
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   MIO_ready      memory access completes this cycle
//   zero/overflow  ALU flags (zero is consumed by the datapath branch logic)
//   inst           instruction register; opcode [31:26], funct [5:0]
//   MemRead..CPU_MIO  1-bit datapath strobes and selects
//   RegDst, MemtoReg, ALUSrcB, PCSource  2-bit mux selects
//   ALU_operation  3-bit ALU opcode
//   state_out      current state code
//   bus_err        memory timeout flag (high while in ERR)
//   trap           one-cycle overflow trap pulse
// -----------------------------------------------------------------------------
module mc_ctrl_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MIO_ready,
  input  logic        zero,
  input  logic        overflow,
  input  logic [31:0] inst,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic        CPU_MIO,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic [4:0]  state_out,
  output logic        bus_err,
  output logic        trap
);

  typedef enum logic [4:0] {
    S_IF   = 5'd0,
    S_ID   = 5'd1,
    S_MA   = 5'd2,
    S_MRD  = 5'd3,
    S_LWB  = 5'd4,
    S_MWR  = 5'd5,
    S_REX  = 5'd6,
    S_RWB  = 5'd7,
    S_BR   = 5'd8,
    S_JMP  = 5'd9,
    S_IEX  = 5'd10,
    S_IWB  = 5'd11,
    S_TRAP = 5'd12,
    S_ERR  = 5'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b011;

  // Counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q,  wait_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_state;
  logic       timeout;

  assign opcode = inst[31:26];
  assign funct  = inst[5:0];

  // The memory states are the only ones the watchdog guards.
  assign mem_state = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
  // Ready wins: timeout fires only when the access has not completed.
  assign timeout   = !MIO_ready && (wait_q == WAIT_LAST);

  // Only opcode/funct are decoded here; the datapath consumes zero and the rest of inst.
`ifdef MC_OVF_TRAP_EN
  logic unused_bits;
  assign unused_bits = ^{inst[25:6], zero};
`else
  logic unused_bits;
  assign unused_bits = ^{inst[25:6], zero, overflow};
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (MIO_ready)    state_d = S_ID;
        else if (timeout) state_d = S_ERR;
      end
      S_ID: begin
        case (opcode)
          OP_RTYPE:                          state_d = S_REX;
          OP_LW, OP_SW:                      state_d = S_MA;
          OP_BEQ, OP_BNE:                    state_d = S_BR;
          OP_J:                              state_d = S_JMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEX;
          default:                           state_d = S_IF;
        endcase
      end
      S_MA:  state_d = (opcode == OP_SW) ? S_MWR : S_MRD;
      S_MRD: begin
        if (MIO_ready)    state_d = S_LWB;
        else if (timeout) state_d = S_ERR;
      end
      S_MWR: begin
        if (MIO_ready)    state_d = S_IF;
        else if (timeout) state_d = S_ERR;
      end
      S_REX: begin
        state_d = S_RWB;
`ifdef MC_OVF_TRAP_EN
        if (overflow && ((funct == FN_ADD) || (funct == FN_SUB))) state_d = S_TRAP;
`endif
      end
      S_IEX: begin
        state_d = S_IWB;
`ifdef MC_OVF_TRAP_EN
        if (overflow && (opcode == OP_ADDI)) state_d = S_TRAP;
`endif
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IF;  // LWB, RWB, BR, JMP, IWB, TRAP
    endcase
  end

  // Wait counter restarts whenever the state changes and counts stalled cycles.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)          wait_d = '0;
    else if (mem_state && !MIO_ready) wait_d = wait_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    CPU_MIO       = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ALU_operation = 3'b000;
    bus_err       = 1'b0;
    trap          = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead       = 1'b1;
        CPU_MIO       = 1'b1;
        ALUSrcB       = 2'b01;
        ALU_operation = ALU_ADD;
        IRWrite       = MIO_ready;
        PCWrite       = MIO_ready;
      end
      S_ID: begin
        ALUSrcB       = 2'b11;
        ALU_operation = ALU_ADD;
      end
      S_MA: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = ALU_ADD;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        CPU_MIO = 1'b1;
      end
      S_LWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        CPU_MIO  = 1'b1;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        case (funct)
          FN_SUB:  ALU_operation = ALU_SUB;
          FN_AND:  ALU_operation = ALU_AND;
          FN_OR:   ALU_operation = ALU_OR;
          FN_SLT:  ALU_operation = ALU_SLT;
          FN_NOR:  ALU_operation = ALU_NOR;
          FN_XOR:  ALU_operation = ALU_XOR;
          default: ALU_operation = ALU_ADD;
        endcase
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
      end
      S_BR: begin
        ALUSrcA       = 1'b1;
        ALU_operation = ALU_SUB;
        PCWriteCond   = 1'b1;
        PCSource      = 2'b01;
        Branch        = (opcode == OP_BEQ);
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (opcode)
          OP_ANDI: ALU_operation = ALU_AND;
          OP_ORI:  ALU_operation = ALU_OR;
          OP_SLTI: ALU_operation = ALU_SLT;
          default: ALU_operation = ALU_ADD;
        endcase
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      S_TRAP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
`ifdef MC_OVF_TRAP_EN
        trap     = 1'b1;
`endif
      end
      S_ERR: begin
        bus_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_unit -- self-checking bench for mc_ctrl_unit.
// Directed scenarios followed by randomized cycles, all compared every cycle
// against a behavioural model of the instruction flow.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_unit;

  localparam int TB_TIMEOUT = 4;

  // Model state numbering follows the published state codes.
  localparam int M_IF = 0, M_ID = 1, M_MA = 2, M_MRD = 3, M_LWB = 4, M_MWR = 5,
                 M_REX = 6, M_RWB = 7, M_BR = 8, M_JMP = 9, M_IEX = 10,
                 M_IWB = 11, M_TRAP = 12, M_ERR = 13;

`ifdef MC_OVF_TRAP_EN
  localparam int EXP_OVF_STATE = M_TRAP;
`else
  localparam int EXP_OVF_STATE = M_RWB;
`endif

  localparam logic [31:0] I_LW   = {6'h23, 26'h0012345};
  localparam logic [31:0] I_SW   = {6'h2b, 26'h0054321};
  localparam logic [31:0] I_BEQ  = {6'h04, 26'h0000010};
  localparam logic [31:0] I_BNE  = {6'h05, 26'h0000020};
  localparam logic [31:0] I_ADD  = {6'h00, 20'h12345, 6'h20};

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, reg_write, alu_src_a;
    logic       pc_write, pc_write_cond, branch, cpu_mio;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       bus_err, trap;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MIO_ready = 1'b0;
  logic        zero = 1'b0;
  logic        overflow = 1'b0;
  logic [31:0] inst = '0;
  logic        MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA;
  logic        PCWrite, PCWriteCond, Branch, CPU_MIO;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0]  ALU_operation;
  logic [4:0]  state_out;
  logic        bus_err, trap;
  outs_t       act;

  mc_ctrl_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .MIO_ready(MIO_ready), .zero(zero), .overflow(overflow),
    .inst(inst), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Branch(Branch), .CPU_MIO(CPU_MIO), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALU_operation(ALU_operation), .state_out(state_out), .bus_err(bus_err),
    .trap(trap)
  );

  assign act = {MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite,
                PCWriteCond, Branch, CPU_MIO, RegDst, MemtoReg, ALUSrcB, PCSource,
                ALU_operation, bus_err, trap};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_state = 0;
  int m_stall = 0;   // consecutive not-ready cycles spent in the current state
  bit m_valid = 1'b0;

  function automatic logic [2:0] alu_rtype(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      6'h27:   return 3'b100;
      6'h26:   return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] alu_imm(input logic [5:0] op);
    case (op)
      6'h0c:   return 3'b000;
      6'h0d:   return 3'b001;
      6'h0a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic outs_t model_outs(input int st, input logic rdy, input logic [31:0] ins);
    outs_t o;
    o = '0;
    case (st)
      M_IF:  begin o.mem_read = 1; o.cpu_mio = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b010;
                   o.ir_write = rdy; o.pc_write = rdy; end
      M_ID:  begin o.alu_src_b = 2'b11; o.alu_op = 3'b010; end
      M_MA:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b010; end
      M_MRD: begin o.mem_read = 1; o.iord = 1; o.cpu_mio = 1; end
      M_LWB: begin o.reg_write = 1; o.mem_to_reg = 2'b01; end
      M_MWR: begin o.mem_write = 1; o.iord = 1; o.cpu_mio = 1; end
      M_REX: begin o.alu_src_a = 1; o.alu_op = alu_rtype(ins[5:0]); end
      M_RWB: begin o.reg_write = 1; o.reg_dst = 2'b01; end
      M_BR:  begin o.alu_src_a = 1; o.alu_op = 3'b110; o.pc_write_cond = 1;
                   o.pc_source = 2'b01; o.branch = (ins[31:26] == 6'h04); end
      M_JMP: begin o.pc_write = 1; o.pc_source = 2'b10; end
      M_IEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = alu_imm(ins[31:26]); end
      M_IWB: o.reg_write = 1;
      M_TRAP: begin o.pc_write = 1; o.pc_source = 2'b11;
`ifdef MC_OVF_TRAP_EN
                   o.trap = 1;
`endif
              end
      M_ERR: o.bus_err = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic model_clock(input logic r, input logic rdy, input logic ovf, input logic [31:0] ins);
    int nxt;
    logic [5:0] op;
    logic [5:0] fn;
    if (r) begin
      m_state = M_IF; m_stall = 0; m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    op  = ins[31:26];
    fn  = ins[5:0];
    nxt = m_state;
    case (m_state)
      M_IF, M_MRD, M_MWR: begin
        if (rdy)
          nxt = (m_state == M_IF) ? M_ID : (m_state == M_MRD) ? M_LWB : M_IF;
        else if (m_stall + 1 >= TB_TIMEOUT)
          nxt = M_ERR;
      end
      M_ID: begin
        if (op == 6'h00)                                        nxt = M_REX;
        else if (op == 6'h23 || op == 6'h2b)                    nxt = M_MA;
        else if (op == 6'h04 || op == 6'h05)                    nxt = M_BR;
        else if (op == 6'h02)                                   nxt = M_JMP;
        else if (op inside {6'h08, 6'h0c, 6'h0d, 6'h0a})        nxt = M_IEX;
        else                                                    nxt = M_IF;
      end
      M_MA:  nxt = (op == 6'h2b) ? M_MWR : M_MRD;
      M_REX: begin
        nxt = M_RWB;
`ifdef MC_OVF_TRAP_EN
        if (ovf && (fn == 6'h20 || fn == 6'h22)) nxt = M_TRAP;
`endif
      end
      M_IEX: begin
        nxt = M_IWB;
`ifdef MC_OVF_TRAP_EN
        if (ovf && op == 6'h08) nxt = M_TRAP;
`endif
      end
      M_ERR:   nxt = M_ERR;
      default: nxt = M_IF;
    endcase
    if (nxt == m_state && !rdy) m_stall++;
    else                        m_stall = 0;
    m_state = nxt;
    if (ovf && fn == 6'h3f) m_stall = m_stall;  // keep ovf/fn referenced in every build
  endtask

  // ---------------------------------------------------------------------------
  // One clock: drive on the falling edge, compare, then advance the model.
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic rdy, input logic z, input logic o,
                      input logic [31:0] ins);
    outs_t exp_o;
    @(negedge clk);
    rst = r; MIO_ready = rdy; zero = z; overflow = o; inst = ins;
    #1;
    if (m_valid) begin
      exp_o = model_outs(m_state, rdy, ins);
      check("state", {27'd0, state_out}, m_state);
      check("outs", {9'd0, act}, {9'd0, exp_o});
    end
    @(posedge clk);
    model_clock(r, rdy, o, ins);
  endtask

  task automatic expect_state(input string tag, input int s);
    #1;
    check(tag, {27'd0, state_out}, s);
  endtask

  logic [5:0] op_tab [11];
  logic [5:0] fn_tab [8];
  logic [31:0] cur_inst;

  initial begin
    op_tab = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h3f};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h26, 6'h00};

    // lw with memory always ready: IF ID MA MRD LWB IF
    step(1, 1, 0, 0, I_LW); expect_state("reset_if", M_IF);
    check("reset_bus_err", {31'd0, bus_err}, 0);
    check("reset_trap", {31'd0, trap}, 0);
    step(0, 1, 0, 0, I_LW); expect_state("lw_id", M_ID);
    step(0, 1, 0, 0, I_LW); expect_state("lw_ma", M_MA);
    step(0, 1, 0, 0, I_LW); expect_state("lw_mrd", M_MRD);
    step(0, 1, 0, 0, I_LW); expect_state("lw_lwb", M_LWB);
    check("lwb_regwrite", {31'd0, RegWrite}, 1);
    check("lwb_memtoreg", {30'd0, MemtoReg}, 2'b01);
    step(0, 1, 0, 0, I_LW); expect_state("lw_if", M_IF);

    // sw with three stalled cycles in MWR
    step(0, 1, 0, 0, I_SW);
    step(0, 1, 0, 0, I_SW);
    step(0, 1, 0, 0, I_SW); expect_state("sw_mwr", M_MWR);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, I_SW); expect_state("sw_hold", M_MWR);
      check("sw_memwrite", {31'd0, MemWrite}, 1);
    end
    step(0, 1, 0, 0, I_SW); expect_state("sw_done", M_IF);
    check("sw_bus_err", {31'd0, bus_err}, 0);

    // Fetch timeout: four stalled IF cycles then ERR, sticky until reset
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, I_LW); expect_state("to_if_hold", M_IF);
    end
    step(0, 0, 0, 0, I_LW); expect_state("to_err", M_ERR);
    check("to_bus_err", {31'd0, bus_err}, 1);
    step(0, 1, 0, 0, I_LW); expect_state("err_sticky", M_ERR);
    step(1, 1, 0, 0, I_LW); expect_state("err_reset", M_IF);
    check("err_cleared", {31'd0, bus_err}, 0);

    // Ready on the last allowed cycle completes normally
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, I_BNE);
    step(0, 1, 0, 0, I_BNE); expect_state("ready_wins", M_ID);

    // bne with zero=0, then beq with zero=1
    step(0, 1, 0, 0, I_BNE); expect_state("bne_br", M_BR);
    check("bne_branch", {31'd0, Branch}, 0);
    check("bne_alu", {29'd0, ALU_operation}, 3'b110);
    step(0, 1, 0, 0, I_BNE);
    step(0, 1, 1, 0, I_BEQ);
    step(0, 1, 1, 0, I_BEQ); expect_state("beq_br", M_BR);
    check("beq_branch", {31'd0, Branch}, 1);
    check("beq_pcwc", {31'd0, PCWriteCond}, 1);
    step(0, 1, 1, 0, I_BEQ);

    // R-type add with overflow
    step(0, 1, 0, 1, I_ADD);
    step(0, 1, 0, 1, I_ADD); expect_state("add_rex", M_REX);
    step(0, 1, 0, 1, I_ADD); expect_state("add_ovf", EXP_OVF_STATE);
    check("add_ovf_regwrite", {31'd0, RegWrite}, (EXP_OVF_STATE == M_RWB) ? 1 : 0);
    check("add_ovf_trap", {31'd0, trap}, (EXP_OVF_STATE == M_TRAP) ? 1 : 0);
    step(0, 1, 0, 0, I_ADD); expect_state("add_back", M_IF);
    check("trap_one_cycle", {31'd0, trap}, 0);

    // Reset during a stalled MRD clears the wait counter
    step(0, 1, 0, 0, I_LW);
    step(0, 1, 0, 0, I_LW);
    step(0, 1, 0, 0, I_LW); expect_state("mrd_enter", M_MRD);
    step(0, 0, 0, 0, I_LW);
    step(0, 0, 0, 0, I_LW);
    step(1, 0, 0, 0, I_LW); expect_state("mrd_reset", M_IF);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, I_LW); expect_state("cnt_cleared", M_IF);
    end
    step(0, 0, 0, 0, I_LW); expect_state("cnt_to_err", M_ERR);
    step(1, 1, 0, 0, I_LW);

    // Randomized traffic
    cur_inst = I_LW;
    for (int n = 0; n < 3000; n++) begin
      logic r;
      logic rdy;
      logic [5:0] op;
      logic [5:0] fn;
      if (m_state == M_IF) begin
        op = op_tab[$urandom_range(0, 10)];
        fn = fn_tab[$urandom_range(0, 7)];
        if (op == 6'h3f) op = 6'($urandom);
        cur_inst = {op, 20'($urandom), fn};
      end
      r   = ((m_state == M_ERR) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      step(r, rdy, 1'($urandom), 1'($urandom), cur_inst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_unit.md
MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum consecutive MIO_ready-low cycles allowed in any memory state.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; one clock, synchronous, active-high.
REQ-004 SHALL have port MIO_ready, input, 1: memory access completes in the current cycle.
REQ-005 SHALL have ports zero and overflow, input, 1 each: ALU flags (combinational, current cycle).
REQ-006 SHALL have port inst, input, 32: IR contents; opcode inst[31:26], funct inst[5:0].
REQ-007 SHALL have ports MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, CPU_MIO, output, 1 each: datapath strobes and selects.
REQ-008 SHALL have ports RegDst, MemtoReg, ALUSrcB, PCSource, output, 2 each: mux selects.
REQ-009 SHALL have port ALU_operation, output, 3: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT, 100 NOR, 011 XOR.
REQ-010 SHALL have port state_out, output, 5: current state code.
REQ-011 SHALL have ports bus_err and trap, output, 1 each: memory-timeout flag and overflow-trap pulse.

Function
REQ-012 SHALL use state codes IF=0, ID=1, MA=2, MRD=3, LWB=4, MWR=5, REX=6, RWB=7, BR=8, JMP=9, IEX=10, IWB=11, TRAP=12, ERR=13; any output not listed for a state is 0.
REQ-013 IF: MemRead=1, CPU_MIO=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00; IRWrite and PCWrite equal MIO_ready; go to ID when MIO_ready=1, else hold.
REQ-014 ID: ALUSrcA=0, ALUSrcB=11, ADD; next state by opcode: 000000->REX; 100011/101011->MA; 000100/000101->BR; 000010->JMP; 001000/001100/001101/001010->IEX; any other->IF (NOP).
REQ-015 MA: ALUSrcA=1, ALUSrcB=10, ADD; go to MRD for lw, MWR for sw.
REQ-016 MRD: MemRead=1, IorD=1, CPU_MIO=1; hold until MIO_ready, then LWB. LWB: RegWrite=1, RegDst=00, MemtoReg=01; then IF.
REQ-017 MWR: MemWrite=1, IorD=1, CPU_MIO=1; hold until MIO_ready, then IF.
REQ-018 REX: ALUSrcA=1, ALUSrcB=00; funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR, 100110 XOR, other ADD; then RWB. RWB: RegWrite=1, RegDst=01, MemtoReg=00; then IF.
REQ-019 BR: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=01, Branch=1 for beq and 0 for bne; datapath takes the branch when PCWriteCond & (Branch ? zero : ~zero); then IF.
REQ-020 JMP: PCWrite=1, PCSource=10; then IF.
REQ-021 IEX: ALUSrcA=1, ALUSrcB=10; addi ADD, andi AND, ori OR, slti SLT; then IWB. IWB: RegWrite=1, RegDst=00, MemtoReg=00; then IF.
REQ-022 Wait counter: clears on entry to IF/MRD/MWR, increments each cycle MIO_ready=0 in those states; when count reaches TIMEOUT-1 with MIO_ready=0, next state is ERR.
REQ-023 MIO_ready=1 in the same cycle the timeout is reached SHALL complete the access normally (ready wins).
REQ-024 ERR: all strobes 0, bus_err=1; held until rst.
REQ-025 Outputs SHALL be decoded from the state register only, except IRWrite/PCWrite in IF (gated by MIO_ready) and the REX/IEX overflow decision.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IF, wait counter 0, bus_err=0, trap=0, regardless of state, including mid-access or ERR.
REQ-027 In the first cycle after reset, outputs SHALL be the IF values of REQ-013.

Configuration
REQ-028 Macro MC_OVF_TRAP_EN defined: in REX with ADD/SUB or IEX with addi and overflow=1, next state is TRAP instead of RWB/IWB. TRAP: PCWrite=1, PCSource=11, RegWrite=0, trap=1 for one cycle; then IF.
REQ-029 MC_OVF_TRAP_EN undefined: overflow ignored, TRAP unreachable, trap tied 0.

Verification
REQ-030 Reset, then lw opcode, MIO_ready=1 throughout -> state_out 0,1,2,3,4,0; LWB has RegWrite=1, MemtoReg=01.
REQ-031 sw with MIO_ready=0 for 3 cycles in MWR -> MemWrite stays 1 for 4 cycles, then IF; bus_err=0.
REQ-032 TIMEOUT=4, MIO_ready held 0 in IF -> ERR after 4 IF cycles, bus_err=1 until rst pulse returns state 0.
REQ-033 bne with zero=0 -> BR: PCWriteCond=1, Branch=0, ALU_operation=110; beq with zero=1 -> Branch=1.
REQ-034 R-type add with overflow=1 -> TRAP (state 12), trap=1 one cycle, no RegWrite with MC_OVF_TRAP_EN; RWB with RegWrite=1 without.
REQ-035 rst asserted during MRD wait -> state_out=0 next cycle, counter cleared.
